hazard_sched_unit: RTL and testbench

Pipeline hazard controller for the five-stage OTTER pipeline. Detects load-use hazards and stalls Fetch/Decode while inserting a bubble into Execute. Squashes wrong-path instructions after a taken branch/jump resolved in Execute, using a multi-cycle flush sequence. Drives ALU operand forwarding selects and keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/fwd_select.sv | 32 +++
 rtl/hazard_sched_unit.sv | 159 +++++++++++++++
 tb/tb_hazard_sched_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared state encoding and forwarding/PC-source constants for
//            the OTTER pipeline hazard logic.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMS  = 2'b01;
  localparam logic [1:0] FWD_MSWB  = 2'b10;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : ALU operand bypass select for one source register.
// Revision : 1.0
// ============================================================================
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] ex_ms_rd_i,
  input  logic       ex_ms_regwrite_i,
  input  logic       ex_ms_memread_i,
  input  logic [4:0] ms_wb_rd_i,
  input  logic       ms_wb_regwrite_i,
  output logic [1:0] sel_o
);

  // A load in EX/MS has no data yet; the younger stage wins otherwise.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_ms_regwrite_i && !ex_ms_memread_i && (ex_ms_rd_i != 5'd0) &&
        (ex_ms_rd_i == rs_i)) begin
      sel_o = FWD_EXMS;
    end else if (ms_wb_regwrite_i && (ms_wb_rd_i != 5'd0) &&
                 (ms_wb_rd_i == rs_i)) begin
      sel_o = FWD_MSWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_sched_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sched_unit
// Purpose  : Load-use stall, redirect flush sequencing, operand forwarding
//            selects and saturating stall/flush counters.
// Revision : 1.0
// ============================================================================
module hazard_sched_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES      = 2,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             HAZARD_CLOCK,
  input  logic             HAZARD_RESET,
  input  logic [4:0]       DEC_RS1,
  input  logic [4:0]       DEC_RS2,
  input  logic             DEC_RS1_USED,
  input  logic             DEC_RS2_USED,
  input  logic             ID_EX_VALID,
  input  logic [4:0]       ID_EX_RD,
  input  logic             ID_EX_REGWRITE,
  input  logic             ID_EX_MEMREAD2,
  input  logic [1:0]       PCSOURCE,
  input  logic [4:0]       EX_MS_RD,
  input  logic             EX_MS_REGWRITE,
  input  logic             EX_MS_MEMREAD2,
  input  logic [4:0]       MS_WB_RD,
  input  logic             MS_WB_REGWRITE,
  output logic             STALL_FETCH,
  output logic             STALL_DECODE,
  output logic             FLUSH_DECODE,
  output logic             FLUSH_EXECUTE,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT
);

  localparam logic [2:0]       C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0]       C_STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX      = {CNT_W{1'b1}};

  hz_state_t        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic w_redir, w_lu, w_stall, w_flush_dec, w_flush_ex, w_stall_inc, w_flush_inc;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_redir = (state_q != FLUSH) && ID_EX_VALID && (PCSOURCE != PCSRC_SEQ);
  assign w_lu    = ID_EX_VALID && ID_EX_MEMREAD2 && ID_EX_REGWRITE && (ID_EX_RD != 5'd0) &&
                   ((DEC_RS1_USED && (DEC_RS1 == ID_EX_RD)) ||
                    (DEC_RS2_USED && (DEC_RS2 == ID_EX_RD)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_stall     = 1'b0;
    w_flush_dec = 1'b0;
    w_flush_ex  = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (w_redir) begin
      // A redirect also preempts any stall still in progress.
      w_flush_dec = 1'b1;
      w_flush_ex  = 1'b1;
      w_flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = C_FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    end else begin
      unique case (state_q)
        STALL: begin
          w_stall     = 1'b1;
          w_flush_ex  = 1'b1;
          w_stall_inc = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        FLUSH: begin
          w_flush_dec = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        default: begin
          if (w_lu) begin
            w_stall     = 1'b1;
            w_flush_ex  = 1'b1;
            w_stall_inc = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = C_STALL_RELOAD;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall_inc && (stall_cnt_q != C_CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (w_flush_inc && (flush_cnt_q != C_CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge HAZARD_CLOCK or posedge HAZARD_RESET) begin
    if (HAZARD_RESET) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_select u_fwd_a (
    .rs_i             (DEC_RS1),
    .ex_ms_rd_i       (EX_MS_RD),
    .ex_ms_regwrite_i (EX_MS_REGWRITE),
    .ex_ms_memread_i  (EX_MS_MEMREAD2),
    .ms_wb_rd_i       (MS_WB_RD),
    .ms_wb_regwrite_i (MS_WB_REGWRITE),
    .sel_o            (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .rs_i             (DEC_RS2),
    .ex_ms_rd_i       (EX_MS_RD),
    .ex_ms_regwrite_i (EX_MS_REGWRITE),
    .ex_ms_memread_i  (EX_MS_MEMREAD2),
    .ms_wb_rd_i       (MS_WB_RD),
    .ms_wb_regwrite_i (MS_WB_REGWRITE),
    .sel_o            (w_fwd_b)
  );

  // Reset forces a squash of both stages regardless of the clock.
  assign STALL_FETCH   = !HAZARD_RESET && w_stall;
  assign STALL_DECODE  = !HAZARD_RESET && w_stall;
  assign FLUSH_DECODE  = HAZARD_RESET || w_flush_dec;
  assign FLUSH_EXECUTE = HAZARD_RESET || w_flush_ex;
  assign FWD_A_SEL     = HAZARD_RESET ? FWD_RF : w_fwd_a;
  assign FWD_B_SEL     = HAZARD_RESET ? FWD_RF : w_fwd_b;
  assign STALL_COUNT   = stall_cnt_q;
  assign FLUSH_COUNT   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sched_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_sched_unit
// Purpose  : Scoreboard bench for hazard_sched_unit (default and 4-bit
//            counter builds driven in parallel).
// Revision : 1.0
// ============================================================================
module tb_hazard_sched_unit;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic [4:0] r_rs1, r_rs2, r_idex_rd, r_exms_rd, r_mswb_rd;
  logic       r_rs1_used, r_rs2_used, r_idex_valid, r_idex_rw, r_idex_mr;
  logic       r_exms_rw, r_exms_mr, r_mswb_rw;
  logic [1:0] r_pcsrc;

  logic        w_sf, w_sd, w_fd, w_fe, w4_sf, w4_sd, w4_fd, w4_fe;
  logic [1:0]  w_fa, w_fb, w4_fa, w4_fb;
  logic [31:0] w_sc, w_fc;
  logic [3:0]  w4_sc, w4_fc;

  always #5 r_clk = ~r_clk;

  hazard_sched_unit #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .CNT_W(32)) dut (
    .HAZARD_CLOCK(r_clk), .HAZARD_RESET(r_rst),
    .DEC_RS1(r_rs1), .DEC_RS2(r_rs2), .DEC_RS1_USED(r_rs1_used), .DEC_RS2_USED(r_rs2_used),
    .ID_EX_VALID(r_idex_valid), .ID_EX_RD(r_idex_rd), .ID_EX_REGWRITE(r_idex_rw),
    .ID_EX_MEMREAD2(r_idex_mr), .PCSOURCE(r_pcsrc),
    .EX_MS_RD(r_exms_rd), .EX_MS_REGWRITE(r_exms_rw), .EX_MS_MEMREAD2(r_exms_mr),
    .MS_WB_RD(r_mswb_rd), .MS_WB_REGWRITE(r_mswb_rw),
    .STALL_FETCH(w_sf), .STALL_DECODE(w_sd), .FLUSH_DECODE(w_fd), .FLUSH_EXECUTE(w_fe),
    .FWD_A_SEL(w_fa), .FWD_B_SEL(w_fb), .STALL_COUNT(w_sc), .FLUSH_COUNT(w_fc)
  );

  hazard_sched_unit #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .CNT_W(4)) dut4 (
    .HAZARD_CLOCK(r_clk), .HAZARD_RESET(r_rst),
    .DEC_RS1(r_rs1), .DEC_RS2(r_rs2), .DEC_RS1_USED(r_rs1_used), .DEC_RS2_USED(r_rs2_used),
    .ID_EX_VALID(r_idex_valid), .ID_EX_RD(r_idex_rd), .ID_EX_REGWRITE(r_idex_rw),
    .ID_EX_MEMREAD2(r_idex_mr), .PCSOURCE(r_pcsrc),
    .EX_MS_RD(r_exms_rd), .EX_MS_REGWRITE(r_exms_rw), .EX_MS_MEMREAD2(r_exms_mr),
    .MS_WB_RD(r_mswb_rd), .MS_WB_REGWRITE(r_mswb_rw),
    .STALL_FETCH(w4_sf), .STALL_DECODE(w4_sd), .FLUSH_DECODE(w4_fd), .FLUSH_EXECUTE(w4_fe),
    .FWD_A_SEL(w4_fa), .FWD_B_SEL(w4_fb), .STALL_COUNT(w4_sc), .FLUSH_COUNT(w4_fc)
  );

  typedef struct {
    string       nm;
    logic [3:0]  ctl;   // {stall_fetch, stall_decode, flush_decode, flush_execute}
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
    logic [3:0]  sc4, fc4;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_sc = 0, m_fc = 0;
  logic [3:0]  m_sc4 = 0, m_fc4 = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whatever was queued.
  always @(negedge r_clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "ctl",  {28'd0, w_sf, w_sd, w_fd, w_fe}, {28'd0, e.ctl});
      chk(e.nm, "ctl4", {28'd0, w4_sf, w4_sd, w4_fd, w4_fe}, {28'd0, e.ctl});
      chk(e.nm, "fwd_a", {30'd0, w_fa}, {30'd0, e.fa});
      chk(e.nm, "fwd_b", {30'd0, w_fb}, {30'd0, e.fb});
      chk(e.nm, "stall_cnt", w_sc, e.sc);
      chk(e.nm, "flush_cnt", w_fc, e.fc);
      chk(e.nm, "stall_cnt4", {28'd0, w4_sc}, {28'd0, e.sc4});
      chk(e.nm, "flush_cnt4", {28'd0, w4_fc}, {28'd0, e.fc4});
    end
  end

  task automatic push_exp(input string nm, input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.fa = fa; e.fb = fb;
    e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
    q.push_back(e);
  endtask

  // Queue expectation for this cycle, account for counter bumps at the next edge, advance.
  task automatic cyc(input string nm, input logic [3:0] ctl, input logic [1:0] fa,
                     input logic [1:0] fb, input bit sinc, input bit finc);
    push_exp(nm, ctl, fa, fb);
    if (sinc) begin m_sc = m_sc + 1; m_sc4 = (m_sc4 == 4'hF) ? 4'hF : m_sc4 + 4'd1; end
    if (finc) begin m_fc = m_fc + 1; m_fc4 = (m_fc4 == 4'hF) ? 4'hF : m_fc4 + 4'd1; end
    @(posedge r_clk); #1;
  endtask

  task automatic clr();
    r_rs1 = 0; r_rs2 = 0; r_rs1_used = 0; r_rs2_used = 0;
    r_idex_valid = 0; r_idex_rd = 0; r_idex_rw = 0; r_idex_mr = 0; r_pcsrc = 2'b00;
    r_exms_rd = 0; r_exms_rw = 0; r_exms_mr = 0; r_mswb_rd = 0; r_mswb_rw = 0;
  endtask

  task automatic set_lw5();
    r_idex_valid = 1; r_idex_mr = 1; r_idex_rw = 1; r_idex_rd = 5'd5;
  endtask

  initial begin
    clr();
    // Reset: forwarding match present but selects must be forced to RF.
    r_rs1 = 5'd7; r_exms_rd = 5'd7; r_exms_rw = 1;
    repeat (2) @(posedge r_clk); #1;
    cyc("reset", 4'b0011, 2'b00, 2'b00, 0, 0);
    r_rst = 0; clr();
    cyc("post_rst", 4'b0000, 2'b00, 2'b00, 0, 0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in Decode.
    set_lw5(); r_rs1 = 5'd5; r_rs1_used = 1; r_rs2 = 5'd1; r_rs2_used = 1;
    cyc("lu", 4'b1101, 2'b00, 2'b00, 1, 0);
    r_idex_valid = 0; r_mswb_rd = 5'd5; r_mswb_rw = 1;
    cyc("lu_fwd", 4'b0000, 2'b10, 2'b00, 0, 0);
    clr();
    cyc("idle", 4'b0000, 2'b00, 2'b00, 0, 0);

    // Taken branch followed by a second (ignored) redirect in the flush cycle.
    r_idex_valid = 1; r_pcsrc = 2'b10;
    cyc("br_c0", 4'b0011, 2'b00, 2'b00, 0, 1);
    r_pcsrc = 2'b01;
    cyc("br_c1", 4'b0010, 2'b00, 2'b00, 0, 0);
    clr();
    cyc("br_c2", 4'b0000, 2'b00, 2'b00, 0, 0);

    // Redirect and load-use together; load-use still present in flush cycle.
    set_lw5(); r_pcsrc = 2'b01; r_rs2 = 5'd5; r_rs2_used = 1;
    cyc("redir_lu", 4'b0011, 2'b00, 2'b00, 0, 1);
    cyc("flush_lu", 4'b0010, 2'b00, 2'b00, 0, 0);
    clr();
    cyc("idle2", 4'b0000, 2'b00, 2'b00, 0, 0);

    // Forwarding priority.
    r_rs2 = 5'd7; r_exms_rd = 5'd7; r_exms_rw = 1; r_mswb_rd = 5'd7; r_mswb_rw = 1;
    cyc("fwd_both", 4'b0000, 2'b00, 2'b01, 0, 0);
    r_exms_mr = 1;
    cyc("fwd_ld", 4'b0000, 2'b00, 2'b10, 0, 0);
    r_exms_rd = 0; r_mswb_rd = 0; r_rs2 = 0;
    cyc("fwd_x0", 4'b0000, 2'b00, 2'b00, 0, 0);
    r_exms_mr = 0; r_rs1 = 5'd9; r_rs2 = 5'd3; r_exms_rd = 5'd9; r_mswb_rd = 5'd3;
    cyc("fwd_ab", 4'b0000, 2'b01, 2'b10, 0, 0);
    clr();

    // Asynchronous reset in flush cycle 1.
    r_idex_valid = 1; r_pcsrc = 2'b10;
    cyc("rf_c0", 4'b0011, 2'b00, 2'b00, 0, 1);
    clr();
    #2 r_rst = 1;
    m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    push_exp("rst_async", 4'b0011, 2'b00, 2'b00);
    @(posedge r_clk); #1;
    r_rst = 0;
    cyc("rst_rel", 4'b0000, 2'b00, 2'b00, 0, 0);
    cyc("rst_run", 4'b0000, 2'b00, 2'b00, 0, 0);

    // 20 back-to-back load-use cycles: 4-bit counter must saturate at 15.
    set_lw5(); r_rs1 = 5'd5; r_rs1_used = 1;
    for (int i = 0; i < 20; i++) cyc("sat", 4'b1101, 2'b00, 2'b00, 1, 0);
    clr();
    cyc("sat_end", 4'b0000, 2'b00, 2'b00, 0, 0);
    chk("sat_model", "stall_cnt4", {28'd0, w4_sc}, 32'd15);

    repeat (3) @(posedge r_clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
